// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte FIFO for the Wishbone UART.
// One byte may be pushed per clock by the RX deserializer; the bus side
// sees the four oldest bytes packed little-endian and may pop 0-4 of them
// per strobe. A byte popped in a cycle frees room for a same-cycle push.
module uart_rx_fifo #(
  parameter int FIFO_SIZE      = 8,
  parameter bit ALLOW_OVERFLOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] size,
  input  logic        write_strobe,
  input  logic [7:0]  write_data,
  output logic [31:0] write_available,
  input  logic        read_strobe,
  input  logic [2:0]  read_strobe_count,
  output logic [31:0] read_data,
  output logic [2:0]  read_data_count,
  output logic [31:0] read_count,
  output logic        overflow,
  output logic        underflow,
  output logic        full,
  output logic        empty
);

  localparam int DEPTH = 1 << FIFO_SIZE;
  localparam int PW    = FIFO_SIZE;      // pointer width
  localparam int OW    = FIFO_SIZE + 1;  // occupancy width, holds 0..DEPTH

  // storage and pointers
  logic [7:0]    mem_r [DEPTH];
  logic [PW-1:0] in_ptr_r;
  logic [PW-1:0] out_ptr_r;
  logic [PW-1:0] in_ptr_nxt_s;
  logic [PW-1:0] out_ptr_nxt_s;
  logic [OW-1:0] occ_r;
  logic [OW-1:0] occ_nxt_s;
  logic [31:0]   occ_ext_s;

  // per-cycle decisions
  logic [2:0]    req_s;
  logic [2:0]    pops_s;
  logic [31:0]   space_s;
  logic          wr_en_s;
  logic          accept_s;
  logic          drop_oldest_s;
  logic          ovf_s;
  logic          unf_s;

  // registered status
  logic          ovf_r;
  logic          unf_r;
  logic          full_r;
  logic          empty_r;
  logic [31:0]   read_count_r;
  logic [31:0]   write_available_r;

  assign occ_ext_s = 32'(occ_r);

  // Decide pops, underflow, write acceptance and next pointer/occupancy.
  always_comb begin
    req_s         = 3'd0;
    pops_s        = 3'd0;
    unf_s         = 1'b0;
    space_s       = 32'd0;
    wr_en_s       = 1'b0;
    accept_s      = 1'b0;
    drop_oldest_s = 1'b0;
    ovf_s         = 1'b0;

    if (read_strobe) begin
      if (read_strobe_count > 3'd4) begin
        req_s = 3'd4;
      end else begin
        req_s = read_strobe_count;
      end
    end else begin
      req_s = 3'd0;
    end

    // A short FIFO still gives up what it has; only the shortfall is flagged.
    if (32'(req_s) > occ_ext_s) begin
      unf_s  = 1'b1;
      pops_s = 3'(occ_r);
    end else begin
      unf_s  = 1'b0;
      pops_s = req_s;
    end

    space_s = 32'(DEPTH) - occ_ext_s + 32'(pops_s);

    if (write_strobe) begin
      if (space_s != 32'd0) begin
        wr_en_s  = 1'b1;
        accept_s = 1'b1;
      end else begin
        ovf_s = 1'b1;
        if (ALLOW_OVERFLOW) begin
          // Overwrite mode: newest byte wins, the oldest is discarded.
          wr_en_s       = 1'b1;
          drop_oldest_s = 1'b1;
        end else begin
          wr_en_s       = 1'b0;
          drop_oldest_s = 1'b0;
        end
      end
    end else begin
      wr_en_s = 1'b0;
    end

    in_ptr_nxt_s  = in_ptr_r + PW'(wr_en_s);
    out_ptr_nxt_s = out_ptr_r + PW'(pops_s) + PW'(drop_oldest_s);
    occ_nxt_s     = occ_r - OW'(pops_s) + OW'(accept_s);
  end

  // Pointer, occupancy and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ptr_r          <= {PW{1'b0}};
      out_ptr_r         <= {PW{1'b0}};
      occ_r             <= {OW{1'b0}};
      ovf_r             <= 1'b0;
      unf_r             <= 1'b0;
      full_r            <= 1'b0;
      empty_r           <= 1'b1;
      read_count_r      <= 32'd0;
      write_available_r <= 32'(DEPTH);
    end else begin
      in_ptr_r          <= in_ptr_nxt_s;
      out_ptr_r         <= out_ptr_nxt_s;
      occ_r             <= occ_nxt_s;
      ovf_r             <= ovf_s;
      unf_r             <= unf_s;
      full_r            <= (32'(occ_nxt_s) == 32'(DEPTH));
      empty_r           <= (occ_nxt_s == {OW{1'b0}});
      read_count_r      <= 32'(occ_nxt_s);
      write_available_r <= 32'(DEPTH) - 32'(occ_nxt_s);
    end
  end

  // Byte storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[in_ptr_r] <= write_data;
    end
  end

  // Present up to four oldest bytes, zero-filling lanes past the occupancy.
  always_comb begin
    read_data = 32'd0;
    for (int k = 0; k < 4; k++) begin
      if (32'(k) < occ_ext_s) begin
        read_data[8*k +: 8] = mem_r[out_ptr_r + PW'(k)];
      end else begin
        read_data[8*k +: 8] = 8'h00;
      end
    end
    if (occ_ext_s >= 32'd4) begin
      read_data_count = 3'd4;
    end else begin
      read_data_count = 3'(occ_r);
    end
  end

  assign size            = 32'(DEPTH);
  assign write_available = write_available_r;
  assign read_count      = read_count_r;
  assign overflow        = ovf_r;
  assign underflow       = unf_r;
  assign full            = full_r;
  assign empty           = empty_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: drives one stimulus stream into three FIFO builds
// (D=256 overwrite, D=4 overwrite, D=4 drop) and checks each against a
// queue-based model every cycle, plus hand-computed literal expectations.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       write_strobe = 1'b0;
  logic [7:0] write_data = 8'h00;
  logic       read_strobe = 1'b0;
  logic [2:0] read_strobe_count = 3'd0;

  logic [31:0] size_o [3];
  logic [31:0] wa     [3];
  logic [31:0] rd     [3];
  logic [2:0]  rdc    [3];
  logic [31:0] rc     [3];
  logic        ovf    [3];
  logic        unf    [3];
  logic        full_o [3];
  logic        empty_o[3];

  int checks = 0;
  int errors = 0;

  int dep[3] = '{256, 4, 4};
  bit al [3] = '{1'b1, 1'b1, 1'b0};

  logic [7:0] mq [3][$];
  logic       ovf_m [3];
  logic       unf_m [3];

  always #5 clk = ~clk;

  uart_rx_fifo #(.FIFO_SIZE(8), .ALLOW_OVERFLOW(1'b1)) u_big (
    .clk(clk), .rst(rst), .size(size_o[0]),
    .write_strobe(write_strobe), .write_data(write_data), .write_available(wa[0]),
    .read_strobe(read_strobe), .read_strobe_count(read_strobe_count),
    .read_data(rd[0]), .read_data_count(rdc[0]), .read_count(rc[0]),
    .overflow(ovf[0]), .underflow(unf[0]), .full(full_o[0]), .empty(empty_o[0]));

  uart_rx_fifo #(.FIFO_SIZE(2), .ALLOW_OVERFLOW(1'b1)) u_small_ow (
    .clk(clk), .rst(rst), .size(size_o[1]),
    .write_strobe(write_strobe), .write_data(write_data), .write_available(wa[1]),
    .read_strobe(read_strobe), .read_strobe_count(read_strobe_count),
    .read_data(rd[1]), .read_data_count(rdc[1]), .read_count(rc[1]),
    .overflow(ovf[1]), .underflow(unf[1]), .full(full_o[1]), .empty(empty_o[1]));

  uart_rx_fifo #(.FIFO_SIZE(2), .ALLOW_OVERFLOW(1'b0)) u_small_drop (
    .clk(clk), .rst(rst), .size(size_o[2]),
    .write_strobe(write_strobe), .write_data(write_data), .write_available(wa[2]),
    .read_strobe(read_strobe), .read_strobe_count(read_strobe_count),
    .read_data(rd[2]), .read_data_count(rdc[2]), .read_count(rc[2]),
    .overflow(ovf[2]), .underflow(unf[2]), .full(full_o[2]), .empty(empty_o[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of held bytes per build.
  always @(posedge clk or posedge rst) begin
    int req;
    int occ;
    int pops;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        mq[i].delete();
        ovf_m[i] = 1'b0;
        unf_m[i] = 1'b0;
      end
    end else begin
      if (read_strobe) req = (read_strobe_count > 3'd4) ? 4 : int'(read_strobe_count);
      else req = 0;
      for (int i = 0; i < 3; i++) begin
        occ = mq[i].size();
        pops = (req < occ) ? req : occ;
        unf_m[i] = (req > occ);
        ovf_m[i] = 1'b0;
        repeat (pops) void'(mq[i].pop_front());
        if (write_strobe) begin
          if (occ - pops < dep[i]) begin
            mq[i].push_back(write_data);
          end else begin
            ovf_m[i] = 1'b1;
            if (al[i]) begin
              void'(mq[i].pop_front());
              mq[i].push_back(write_data);
            end
          end
        end
      end
    end
  end

  // Compare every build against the model on each falling edge.
  always @(negedge clk) begin
    logic [31:0] exp_rd;
    int n;
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        n = mq[i].size();
        exp_rd = 32'd0;
        for (int k = 0; k < 4; k++) if (k < n) exp_rd[8*k +: 8] = mq[i][k];
        chk($sformatf("m%0d_read_data", i), rd[i], exp_rd);
        chk($sformatf("m%0d_read_data_count", i), 32'(rdc[i]), (n < 4) ? n : 4);
        chk($sformatf("m%0d_read_count", i), rc[i], n);
        chk($sformatf("m%0d_write_available", i), wa[i], dep[i] - n);
        chk($sformatf("m%0d_size", i), size_o[i], dep[i]);
        chk($sformatf("m%0d_full", i), 32'(full_o[i]), 32'(n == dep[i]));
        chk($sformatf("m%0d_empty", i), 32'(empty_o[i]), 32'(n == 0));
        chk($sformatf("m%0d_overflow", i), 32'(ovf[i]), 32'(ovf_m[i]));
        chk($sformatf("m%0d_underflow", i), 32'(unf[i]), 32'(unf_m[i]));
      end
    end
  end

  task automatic cyc(input logic ws, input logic [7:0] wd, input logic rs, input logic [2:0] rcnt);
    @(negedge clk);
    write_strobe = ws;
    write_data = wd;
    read_strobe = rs;
    read_strobe_count = rcnt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    write_strobe = 1'b0;
    read_strobe = 1'b0;
    read_strobe_count = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  logic [7:0] fill [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  initial begin
    // Reset state and fill
    do_reset();
    chk("rst_empty", 32'(empty_o[0]), 32'd1);
    chk("rst_full", 32'(full_o[0]), 32'd0);
    chk("rst_wa_big", wa[0], 32'd256);
    chk("rst_wa_small", wa[1], 32'd4);
    chk("rst_rd", rd[0], 32'd0);
    chk("rst_rdc", 32'(rdc[0]), 32'd0);
    chk("rst_rc", rc[0], 32'd0);
    chk("rst_ovf", 32'(ovf[0]), 32'd0);
    chk("rst_unf", 32'(unf[0]), 32'd0);
    for (int i = 0; i < 5; i++) cyc(1'b1, fill[i], 1'b0, 3'd0);
    chk("fill_rc", rc[0], 32'd5);
    chk("fill_rd", rd[0], 32'h44332211);
    chk("fill_rdc", 32'(rdc[0]), 32'd4);
    chk("fill_ow_rd", rd[1], 32'h55443322);
    chk("fill_ow_ovf", 32'(ovf[1]), 32'd1);
    chk("fill_drop_rd", rd[2], 32'h44332211);

    // Partial pop
    cyc(1'b0, 8'h00, 1'b1, 3'd3);
    chk("pop3_rd", rd[0], 32'h00005544);
    chk("pop3_rdc", 32'(rdc[0]), 32'd2);
    chk("pop3_rc", rc[0], 32'd2);
    chk("pop3_unf", 32'(unf[0]), 32'd0);
    chk("pop3_ow_rd", rd[1], 32'h00000055);

    // Overflow on D=4
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, fill[i], 1'b0, 3'd0);
    chk("of_full", 32'(full_o[1]), 32'd1);
    cyc(1'b1, 8'h99, 1'b0, 3'd0);
    chk("of_ow_ovf", 32'(ovf[1]), 32'd1);
    chk("of_ow_rd", rd[1], 32'h99443322);
    chk("of_ow_rc", rc[1], 32'd4);
    chk("of_drop_ovf", 32'(ovf[2]), 32'd1);
    chk("of_drop_rd", rd[2], 32'h44332211);
    chk("of_big_ovf", 32'(ovf[0]), 32'd0);
    cyc(1'b1, 8'hAA, 1'b0, 3'd0);
    chk("of_repeat_ovf", 32'(ovf[1]), 32'd1);
    chk("of_repeat_rd", rd[1], 32'hAA994433);
    cyc(1'b0, 8'h00, 1'b0, 3'd0);
    chk("of_idle_ovf", 32'(ovf[1]), 32'd0);

    // Wrap-around on D=4
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, fill[i], 1'b0, 3'd0);
    cyc(1'b0, 8'h00, 1'b1, 3'd2);
    cyc(1'b1, 8'hA0, 1'b0, 3'd0);
    cyc(1'b1, 8'hA1, 1'b0, 3'd0);
    chk("wrap_full", 32'(full_o[1]), 32'd1);
    chk("wrap_rd", rd[1], 32'hA1A04433);
    chk("wrap_drop_rd", rd[2], 32'hA1A04433);
    cyc(1'b1, 8'hB0, 1'b1, 3'd1);
    chk("fullrw_ovf", 32'(ovf[1]), 32'd0);
    chk("fullrw_rc", rc[1], 32'd4);
    chk("fullrw_rd", rd[1], 32'hB0A1A044);
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b1, 3'd1);

    // Underflow and simultaneous ops
    do_reset();
    cyc(1'b1, 8'h11, 1'b0, 3'd0);
    cyc(1'b1, 8'h22, 1'b0, 3'd0);
    cyc(1'b0, 8'h00, 1'b1, 3'd4);
    chk("uf_unf", 32'(unf[0]), 32'd1);
    chk("uf_empty", 32'(empty_o[0]), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 3'd0);
    chk("uf_idle_unf", 32'(unf[0]), 32'd0);
    cyc(1'b1, 8'h5A, 1'b1, 3'd1);
    chk("emptyrw_unf", 32'(unf[0]), 32'd1);
    chk("emptyrw_rc", rc[0], 32'd1);
    chk("emptyrw_rd", rd[0], 32'h0000005A);
    cyc(1'b0, 8'h00, 1'b1, 3'd0);
    chk("cnt0_unf", 32'(unf[0]), 32'd0);
    chk("cnt0_rc", rc[0], 32'd1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(i + 2), 1'b0, 3'd0);
    cyc(1'b0, 8'h00, 1'b1, 3'd7);
    chk("cnt7_rc", rc[0], 32'd1);
    chk("cnt7_rd", rd[0], 32'h00000005);
    chk("cnt7_unf", 32'(unf[0]), 32'd0);

    // Asynchronous reset between edges
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h31 + i), 1'b0, 3'd0);
    #2;
    rst = 1'b1;
    write_strobe = 1'b0;
    #1;
    chk("arst_rc", rc[0], 32'd0);
    chk("arst_empty", 32'(empty_o[0]), 32'd1);
    chk("arst_rd", rd[0], 32'd0);
    chk("arst_wa", wa[0], 32'd256);
    @(negedge clk);
    rst = 1'b0;

    // Bulk traffic: fill past D=256, mixed push/pop, then drain
    do_reset();
    for (int i = 0; i < 260; i++) cyc(1'b1, 8'(i * 7 + 3), 1'b0, 3'd0);
    chk("bulk_full", 32'(full_o[0]), 32'd1);
    chk("bulk_ovf", 32'(ovf[0]), 32'd1);
    for (int i = 0; i < 40; i++) cyc(1'b1, 8'(i), 1'b1, 3'(i % 5));
    for (int i = 0; i < 70; i++) cyc(1'b0, 8'h00, 1'b1, 3'd4);
    chk("drain_empty", 32'(empty_o[0]), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side FIFO for the Wishbone UART: accepts one byte per clock from the UART receiver and lets the bus side remove 1–4 bytes per strobe. It presents the four oldest bytes packed little-endian on a 32-bit word. It mirrors the transmit FIFO, which is multi-byte in and single-byte out. It sits between the RX deserializer and the Wishbone register/read logic.

## Interface
Parameters:
- FIFO_SIZE, 8, address width; depth D = 2^FIFO_SIZE bytes (minimum 2).
- ALLOW_OVERFLOW, 1, behaviour on write when full:
  - 1: store the byte and discard the oldest byte.
  - 0: drop the incoming byte.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- size  out  32  constant D.
- write_strobe  in  1  push write_data this cycle.
- write_data  in  8  byte from receiver.
- write_available  out  32  D − occupancy (registered).
- read_strobe  in  1  pop bytes this cycle.
- read_strobe_count  in  3  bytes to pop, 0–4; values 5–7 are treated as 4.
- read_data  out  32  oldest byte in [7:0], next in [15:8], and so on; lanes beyond occupancy read 0x00.
- read_data_count  out  3  min(4, occupancy).
- read_count  out  32  occupancy (registered).
- overflow  out  1  one-cycle pulse.
- underflow  out  1  one-cycle pulse.
- full  out  1  occupancy == D.
- empty  out  1  occupancy == 0.

## Operation
State:
- Circular byte array of depth D.
- in_pointer and out_pointer, FIFO_SIZE bits each; they wrap modulo D naturally.
- Occupancy counter, FIFO_SIZE+1 bits, so all D entries are usable.

Each cycle, with occ = occupancy before the edge:
- Requested pops: req = read_strobe ? clamp(read_strobe_count, 4) : 0.
- Actual pops: pops = min(req, occ).
- Pop: out_pointer += pops.
- Underflow: if req > occ, pulse underflow. Pop whatever is available; a partial pop is legal.
- Write space: space = D − occ + pops. A byte popped this cycle frees space for a same-cycle write.
- Write with space > 0: store at in_pointer, in_pointer += 1.
- Write with space == 0: pulse overflow.
  - ALLOW_OVERFLOW=1: store at in_pointer, in_pointer += 1, and out_pointer advances one extra; occupancy stays D.
  - ALLOW_OVERFLOW=0: drop the byte; pointers unchanged by the write.
- New occupancy = occ − pops + accepted write − dropped-oldest.

Derived outputs:
- read_data and read_data_count are combinational from the array, out_pointer and occupancy.
- Lane k shows array[out_pointer+k mod D] when k < occupancy, else 0x00.
- full, empty, read_count and write_available derive from the registered occupancy.
- Memory contents are not reset.

## Timing
- Reset (asynchronous assert, release synchronous to clk):
  - pointers 0, occupancy 0
  - read_count 0, write_available D, read_data_count 0, read_data 0
  - empty 1, full 0, overflow 0, underflow 0
- Assertion of rst mid-operation discards all contents immediately, without a clock edge.
- Write latency: a byte written at edge N is visible on read_data and counted in read_count after edge N.
- Read latency: popped bytes disappear after the strobe edge. The next bytes appear on read_data in the same cycle the pointer updates, so back-to-back read strobes each cycle are legal.
- overflow and underflow assert for exactly the one cycle following the offending edge; repeated offenses keep them asserted.
- Simultaneous read and write when empty:
  - Any req > 0 raises underflow.
  - The write is accepted; occupancy becomes 1.
- Simultaneous read and write when full with pops ≥ 1: no overflow; occupancy becomes D − pops + 1.
- read_strobe with count 0: no pop and no underflow.

## Test plan
- Reset and fill: after reset, check empty=1, write_available=D, read_data=0. Write 0x11,0x22,0x33,0x44,0x55 on consecutive cycles. Required: read_count=5, read_data=0x44332211, read_data_count=4.
- Partial pop: from the fill state, read_strobe with count 3. Required next cycle: read_data=0x00005544, read_data_count=2, read_count=2, no underflow.
- Wrap-around, FIFO_SIZE=2 (D=4):
  - Write 4 bytes; full=1.
  - Pop 2, write 0xA0,0xA1.
  - Required: full=1, read_data=0xA1A04433 after writing 0x11..0x44, and pointers wrap without corruption.
- Overflow, D=4, full with 0x11..0x44, write 0x99:
  - ALLOW_OVERFLOW=1: overflow pulse, read_data=0x99443322, read_count=4.
  - ALLOW_OVERFLOW=0: overflow pulse, read_data=0x44332211.
- Underflow and simultaneous ops:
  - With 2 bytes held, pop 4: underflow pulse, empty=1.
  - When full, write and pop 1 in the same cycle: no overflow, read_count=D.
  - When empty, write and pop 1: underflow, read_count=1.
- Async reset mid-stream: assert rst between edges while holding 3 bytes. Required: read_count=0, empty=1, read_data=0 before the next clk edge.
